// File: rtl/io_pkg.sv
// Shared types and helpers for the io_bank pad bank: drive FSM state encoding
// and the counter-width function used by the turnaround and filter counters.
package io_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_DRIVE,
    DRIVING
  } io_drive_state_t;

  // Bits needed to hold 0..max_val, never less than 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/io_input_filter.sv
// One pad input bit: multi-flop synchroniser, deglitch counter that only accepts
// a level held for FILTER_LEN synced cycles, and a one-cycle change pulse.
module io_input_filter
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic nReset,
  input  logic pad,
  output logic in_data,
  output logic in_changed
);

  localparam int CW = cnt_width(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      in_data    <= 1'b0;
      in_changed <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pad};
      in_changed <= 1'b0;
      if (synced == in_data) begin
        cnt_q <= '0;
      end else if (int'(cnt_q) + 1 >= FILTER_LEN) begin
        in_data    <= synced;
        cnt_q      <= '0;
        in_changed <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_bank.sv
// Bidirectional pad bank: registered output data, OE sequencing with a
// programmable hi-Z turnaround gap, and filtered inputs with change pulses.
module io_bank
  import io_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TURNAROUND  = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] outData,
  input  logic             outEnable,
  output logic             driving,
  output logic [WIDTH-1:0] inData,
  output logic [WIDTH-1:0] inChanged,
  inout  wire  [WIDTH-1:0] pads
);

  localparam int             TW        = cnt_width(TURNAROUND);
  localparam logic [TW-1:0]  TURN_LOAD = (TURNAROUND > 0) ? TW'(TURNAROUND - 1) : '0;

  io_drive_state_t state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             oe_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      RELEASED: begin
        if (outEnable) begin
          if (TURNAROUND == 0) begin
            state_d = DRIVING;
          end else begin
            state_d = WAIT_DRIVE;
            tcnt_d  = TURN_LOAD;
          end
        end
      end
      WAIT_DRIVE: begin
        if (!outEnable)          state_d = RELEASED;
        else if (tcnt_q == '0)   state_d = DRIVING;
        else                     tcnt_d  = tcnt_q - TW'(1);
      end
      DRIVING: begin
        if (!outEnable) state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
  end

  // OE is registered from the next state so enable and release both take
  // effect right after the deciding edge, with no extra cycle of delay.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= RELEASED;
      tcnt_q  <= '0;
      oe_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      oe_q    <= (state_d == DRIVING);
      data_q  <= outData;
    end
  end

  assign driving = oe_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
    assign pads[gi] = oe_q ? data_q[gi] : 1'bz;

    io_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
      .clk        (clk),
      .nReset     (nReset),
      .pad        (pads[gi]),
      .in_data    (inData[gi]),
      .in_changed (inChanged[gi])
    );
  end

endmodule

// File: doc/io_bank.md
# io_bank

Parametrised bidirectional pad bank for the cart and I/O bus of the 573in1 FPGA design. It provides per-bit registered output data, and output-enable sequencing with a programmable bus-turnaround gap before driving. Inputs pass through a multi-stage synchroniser and a per-bit deglitch filter. Per-bit change pulses are generated from the filtered inputs. The bank sits between the top-level pads and the bus controllers, replacing hand-instantiated tri-state buffers and ad-hoc input flops.

## Interface
Parameters:
- WIDTH, 8, number of pads in the bank (≥1)
- SYNC_STAGES, 2, synchroniser flops per input bit (≥2)
- FILTER_LEN, 3, consecutive cycles a synchronised bit must differ before it is accepted (≥1; 1 = no filtering)
- TURNAROUND, 1, hi-Z cycles inserted between an enable request and driving (≥0)

Ports:
- clk  in  1  single clock for all logic
- nReset  in  1  asynchronous, active-low reset
- outData  in  WIDTH  value to drive onto pads
- outEnable  in  1  request to drive the bank (level)
- driving  out  1  high while pads are actively driven
- inData  out  WIDTH  synchronised, filtered pad value
- inChanged  out  WIDTH  one-cycle pulse per bit when inData toggles
- pads  inout  WIDTH  device pins

## Operation
- Reset (async, nReset low) forces the following immediately:
  - pads go hi-Z, and driving=0;
  - inData, inChanged, sync chains, filter counters and the output data register all go to 0;
  - the FSM goes to RELEASED.
- Drive FSM states: RELEASED, WAIT_DRIVE, DRIVING.
  - RELEASED: outEnable=1 moves to WAIT_DRIVE with the counter loaded to TURNAROUND-1. If TURNAROUND=0, it moves directly to DRIVING.
  - WAIT_DRIVE: the counter decrements each cycle; at 0 the FSM moves to DRIVING. outEnable=0 aborts to RELEASED.
  - DRIVING: outEnable=0 moves to RELEASED.
  - Release is never delayed.
- Pad OE is a register equal to (state==DRIVING). driving equals the same register.
- Output data is registered unconditionally every cycle. The pads present the registered value whenever OE is set.
- Input path, per bit:
  - The pad feeds a SYNC_STAGES flop chain.
  - The filter counter resets to 0 whenever the last sync stage equals inData; otherwise it increments.
  - When the count would reach FILTER_LEN, inData takes the synced value, the counter clears, and inChanged pulses for 1 cycle.
  - A glitch shorter than FILTER_LEN synced cycles never reaches inData.
- While driving, the input path observes the bank's own output (loopback); this is intentional.
- Counter widths are $clog2(FILTER_LEN+1) and $clog2(TURNAROUND+1), with a minimum of 1 bit each.

## Timing
- Output enable, with outEnable first sampled high at edge n:
  - TURNAROUND=0: pads are driven after edge n.
  - TURNAROUND=T>0: the FSM is in WAIT_DRIVE after edge n, and pads are driven after edge n+T.
- Release: outEnable sampled low at edge m puts the pads in hi-Z after edge m. This holds from both WAIT_DRIVE and DRIVING.
- Toggle: a 1-cycle low pulse on outEnable during DRIVING re-enters RELEASED, then WAIT_DRIVE. The full turnaround gap is re-applied.
- Output data: outData sampled at edge k appears on the pads after edge k (1 cycle latency) when OE is set.
- Input latency: a pad change first captured at edge 0 appears on inData after edge SYNC_STAGES+FILTER_LEN-1. This is 4 edges at the defaults.
- inChanged is high for exactly the cycle following the inData update.
- Reset deasserted mid-stream: all state restarts from the reset values. A pad already at 1 produces an inChanged pulse after the normal latency.

## Structure
- Package io_pkg holds the drive FSM state enum (io_drive_state_t: RELEASED, WAIT_DRIVE, DRIVING) and the counter-width helper function.
- Sub-module io_input_filter contains one bit of synchroniser, deglitch counter and change detector. It takes the SYNC_STAGES and FILTER_LEN parameters and is instantiated WIDTH times in a generate loop.
- The top level holds the drive FSM, the turnaround counter, the output data register, the OE register, and WIDTH tri-state pad buffers with an active-high enable.

## Test plan
- Reset, then outEnable=1 with TURNAROUND=2 and outData=8'hA5:
  - pads are Z after edges 0 and 1;
  - pads show A5 after edge 2;
  - driving rises after the same edge.
- With the bank DRIVING, drop outEnable for 1 cycle:
  - pads are Z after that edge;
  - they are driven again exactly 2 cycles (TURNAROUND) after outEnable returns high.
- Defaults, with pad bit 3 stepping 0→1 and held:
  - inData[3]=1 appears 4 edges after the capturing edge;
  - inChanged[3] is high for exactly 1 cycle;
  - other bits stay 0.
- Defaults, with 2-cycle high glitches on pad bit 0 separated by 3 low cycles: inData[0] stays 0 and inChanged[0] never pulses.
- Assert nReset low while DRIVING with inData=8'hFF: pads go Z and all outputs go 0 without waiting for a clk edge.
- TURNAROUND=0, FILTER_LEN=1:
  - outEnable high drives the pads after the same sampling edge;
  - a pad change reaches inData after SYNC_STAGES edges.
